// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS9 generator / checker pair.
// Both ends use x^9 + x^5 + 1 and the same seed.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int PRBS_NB   = 9;
    localparam int PRBS_HIGH = 9;
    localparam int PRBS_LOW  = 5;

    localparam logic [8:0] PRBS_SEED = 9'h1AA;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronizing PRBS9 receive checker with BER counters
// and windowed loss-of-lock detection.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int NB         = PRBS_NB,
    parameter int HIGH       = PRBS_HIGH,
    parameter int LOW        = PRBS_LOW,
    parameter int LOCK_THR   = 32,
    parameter int WIN        = 128,
    parameter int UNLOCK_THR = 16,
    parameter int NB_CNT     = 32
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic              i_data,
    input  logic              i_clear,
    output logic              o_lock,
    output logic              o_err,
    output logic [NB_CNT-1:0] o_bit_count,
    output logic [NB_CNT-1:0] o_err_count
);

    localparam int FW = $clog2(NB + 1);
    localparam int MW = $clog2(LOCK_THR + 1);
    localparam int BW = $clog2(WIN + 1);
    localparam int EW = $clog2(UNLOCK_THR + 1);

    state_t        state;
    logic [NB-1:0] hist;
    logic [FW-1:0] fill_cnt;
    logic [MW-1:0] match_cnt;
    logic [BW-1:0] win_bits;
    logic [EW-1:0] win_errs;

    logic          take;
    logic          pred;
    logic          mismatch;
    logic          filled;
    logic          hit;
    logic          lock_now;
    logic          unlock_now;
    logic          win_end;
    logic          bit_inc;
    logic          err_inc;
    logic          cnt_clr;
    logic [MW-1:0] match_nxt;
    logic [BW-1:0] bits_nxt;
    logic [EW-1:0] errs_nxt;

    assign take      = i_enable && i_valid;
    assign pred      = hist[HIGH-1] ^ hist[LOW-1];
    assign mismatch  = i_data != pred;
    assign filled    = fill_cnt == FW'(NB);
    // An all-zero history is the LFSR lock-up state, never a match.
    assign hit       = !mismatch && (hist != '0);
    assign match_nxt = match_cnt + MW'(1);
    assign bits_nxt  = win_bits + BW'(1);
    assign errs_nxt  = win_errs + EW'(mismatch);

    assign lock_now   = take && (state == SEARCH) && filled
                        && hit && (match_nxt == MW'(LOCK_THR));
    assign unlock_now = take && (state == LOCKED)
                        && (errs_nxt == EW'(UNLOCK_THR));
    assign win_end    = bits_nxt == BW'(WIN);

    assign bit_inc = take && (state == LOCKED);
    assign err_inc = bit_inc && mismatch;
    assign cnt_clr = (i_enable && i_clear) || lock_now;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= SEARCH;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            o_lock    <= 1'b0;
            o_err     <= 1'b0;
        end else if (take) begin
            case (state)
                SEARCH: begin
                    hist  <= {hist[NB-2:0], i_data};
                    o_err <= 1'b0;
                    if (!filled) begin
                        fill_cnt <= fill_cnt + FW'(1);
                    end else if (lock_now) begin
                        state     <= LOCKED;
                        o_lock    <= 1'b1;
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                        win_bits  <= '0;
                        win_errs  <= '0;
                    end else if (hit) begin
                        match_cnt <= match_nxt;
                    end else begin
                        match_cnt <= '0;
                    end
                end
                LOCKED: begin
                    // Free-run the reference so channel errors do not propagate.
                    hist  <= {hist[NB-2:0], pred};
                    o_err <= mismatch;
                    if (unlock_now) begin
                        state     <= SEARCH;
                        o_lock    <= 1'b0;
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                        win_bits  <= '0;
                        win_errs  <= '0;
                    end else if (win_end) begin
                        win_bits <= '0;
                        win_errs <= '0;
                    end else begin
                        win_bits <= bits_nxt;
                        win_errs <= errs_nxt;
                    end
                end
                default: state <= SEARCH;
            endcase
        end else if (i_enable) begin
            o_err <= 1'b0;
        end
    end

    sat_counter #(.W(NB_CNT)) u_bit_cnt (
        .clock (clock),
        .reset (i_reset),
        .inc   (bit_inc),
        .clr   (cnt_clr),
        .count (o_bit_count)
    );

    sat_counter #(.W(NB_CNT)) u_err_cnt (
        .clock (clock),
        .reset (i_reset),
        .inc   (err_inc),
        .clr   (cnt_clr),
        .count (o_err_count)
    );

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: queue-based reference model,
// a 32-bit and a 4-bit counter instance driven in parallel.
module tb_prbs_checker;
    import prbs_pkg::*;

    logic        clock = 1'b0;
    logic        i_reset, i_enable, i_valid, i_data, i_clear;
    logic        o_lock, o_err;
    logic [31:0] o_bit_count, o_err_count;
    logic        lock4, err4;
    logic [3:0]  bits4, errs4;

    always #5 clock = ~clock;

    prbs_checker dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_clear     (i_clear),
        .o_lock      (o_lock),
        .o_err       (o_err),
        .o_bit_count (o_bit_count),
        .o_err_count (o_err_count)
    );

    prbs_checker #(.NB_CNT(4)) dut4 (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_clear     (i_clear),
        .o_lock      (lock4),
        .o_err       (err4),
        .o_bit_count (bits4),
        .o_err_count (errs4)
    );

    typedef struct {
        bit     lock;
        bit     err;
        longint bits;
        longint errs;
        longint bits4;
        longint errs4;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit     m_locked;
    bit     rx[$];
    bit     refq[$];
    bit     gen[$];
    int     m_seen, m_match, m_wb, m_we;
    longint mb, me, mb4, me4;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint max);
        return (v < max) ? v + 1 : max;
    endfunction

    function automatic bit gen_next();
        bit b;
        b = gen[0] ^ gen[4];
        gen.push_back(b);
        void'(gen.pop_front());
        return b;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        rx.delete();
        refq.delete();
        m_seen = 0; m_match = 0; m_wb = 0; m_we = 0;
        mb = 0; me = 0; mb4 = 0; me4 = 0;
    endtask

    task automatic model_step(input bit d, input bit clr);
        bit p, nz, e;
        exp_t x;
        e = 0;
        if (!m_locked) begin
            if (m_seen >= 9) begin
                p  = rx[0] ^ rx[4];
                nz = 0;
                foreach (rx[i]) nz |= rx[i];
                m_match = (d == p && nz) ? m_match + 1 : 0;
            end else begin
                m_seen++;
            end
            rx.push_back(d);
            if (rx.size() > 9) void'(rx.pop_front());
            if (m_match == 32) begin
                m_locked = 1;
                refq = rx;
                m_match = 0; m_seen = 0; m_wb = 0; m_we = 0;
                mb = 0; me = 0; mb4 = 0; me4 = 0;
            end
        end else begin
            p = refq[0] ^ refq[4];
            refq.push_back(p);
            void'(refq.pop_front());
            e = d != p;
            mb  = sat(mb, 64'hFFFF_FFFF);
            mb4 = sat(mb4, 15);
            if (e) begin
                me  = sat(me, 64'hFFFF_FFFF);
                me4 = sat(me4, 15);
            end
            m_wb++;
            m_we += int'(e);
            if (m_we == 16) begin
                m_locked = 0;
                rx.delete();
                m_seen = 0; m_match = 0; m_wb = 0; m_we = 0;
            end else if (m_wb == 128) begin
                m_wb = 0; m_we = 0;
            end
        end
        if (clr) begin
            mb = 0; me = 0; mb4 = 0; me4 = 0;
        end
        x = '{m_locked, e, mb, me, mb4, me4};
        sb.push_back(x);
    endtask

    task automatic drive(input bit v, input bit d, input bit clr, input bit en);
        @(posedge clock);
        #2;
        i_enable = en;
        i_valid  = v;
        i_data   = d;
        i_clear  = clr;
        if (en && v) model_step(d, clr);
        else if (en && clr) begin
            mb = 0; me = 0; mb4 = 0; me4 = 0;
        end
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) drive(1, gen_next(), 0, 1);
    endtask

    task automatic settle();
        drive(0, 0, 0, 1);
        @(negedge clock);
    endtask

    task automatic async_reset();
        settle();
        @(posedge clock);
        #3 i_reset = 1;
        #1;
        check("rst_lock", o_lock, 0);
        check("rst_err", o_err, 0);
        check("rst_bits", o_bit_count, 0);
        check("rst_errs", o_err_count, 0);
        check("rst_bits4", bits4, 0);
        #3 i_reset = 0;
        model_reset();
        check("rst_sb_empty", sb.size(), 0);
    endtask

    // Monitor: one expected entry per valid bit, compared a half cycle later
    initial begin
        bit   v;
        exp_t x;
        forever begin
            @(posedge clock);
            v = i_enable && i_valid && !i_reset;
            @(negedge clock);
            if (v) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    x = sb.pop_front();
                    check("lock", o_lock, x.lock);
                    check("err", o_err, x.err);
                    check("bit_count", o_bit_count, x.bits);
                    check("err_count", o_err_count, x.errs);
                    check("bit_count4", bits4, x.bits4);
                    check("err_count4", errs4, x.errs4);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] seed;
        bit v, en, fl, cl;
        seed = PRBS_SEED;
        for (int i = 8; i >= 0; i--) gen.push_back(seed[i]);
        model_reset();
        i_reset = 1; i_enable = 0; i_valid = 0; i_data = 0; i_clear = 0;
        #12;
        check("init_lock", o_lock, 0);
        check("init_err", o_err, 0);
        check("init_bits", o_bit_count, 0);
        check("init_errs", o_err_count, 0);
        @(posedge clock);
        #2 i_reset = 0;

        // Clean stream: lock after bit 41, then 1000 counted bits
        clean(40);
        settle();
        check("no_lock_at_40", o_lock, 0);
        clean(1);
        settle();
        check("lock_at_41", o_lock, 1);
        clean(1000);
        settle();
        check("clean_bits", o_bit_count, 1000);
        check("clean_errs", o_err_count, 0);
        check("sat4_bits", bits4, 15);

        // Single inverted bit
        clean(50);
        drive(1, ~gen_next(), 0, 1);
        clean(100);
        settle();
        check("single_errs", o_err_count, 1);
        check("single_lock", o_lock, 1);

        // Up to 15 errors per window keeps lock
        for (int i = 0; i < 600; i++) drive(1, gen_next() ^ ((i % 8 == 0) && m_we < 15), 0, 1);
        settle();
        check("win15_lock", o_lock, 1);

        // 16 errors at a window start drop lock, then relock after 41 bits
        while (m_wb != 0) drive(1, gen_next(), 0, 1);
        for (int i = 0; i < 16; i++) drive(1, ~gen_next(), 0, 1);
        settle();
        check("win16_unlock", o_lock, 0);
        clean(40);
        settle();
        check("relock_not_yet", o_lock, 0);
        clean(1);
        settle();
        check("relock", o_lock, 1);

        // Clear on an erroneous bit
        clean(20);
        drive(1, ~gen_next(), 1, 1);
        settle();
        check("clr_bits", o_bit_count, 0);
        check("clr_errs", o_err_count, 0);

        // Asynchronous reset mid-lock, then relock
        async_reset();
        clean(41);
        settle();
        check("post_rst_lock", o_lock, 1);

        // Constant zero never locks
        async_reset();
        for (int i = 0; i < 500; i++) drive(1, 0, 0, 1);
        settle();
        check("zero_no_lock", o_lock, 0);

        // Clean stream with random valid gaps gives gap-free counts
        async_reset();
        for (int n = 0; n < 1041;) begin
            v = $urandom_range(0, 2) != 0;
            if (v) begin
                drive(1, gen_next(), 0, 1);
                n++;
            end else begin
                drive(0, $urandom_range(0, 1), 0, 1);
            end
        end
        settle();
        check("gap_bits", o_bit_count, 1000);
        check("gap_errs", o_err_count, 0);

        // Random mix of gaps, enable stalls, errors and clears
        for (int i = 0; i < 4000; i++) begin
            v  = $urandom_range(0, 3) != 0;
            en = $urandom_range(0, 15) != 0;
            fl = $urandom_range(0, 60) == 0;
            cl = $urandom_range(0, 300) == 0;
            if (en && v) drive(1, gen_next() ^ fl, cl, 1);
            else drive(v, $urandom_range(0, 1), cl, en);
        end
        settle();
        settle();
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side PRBS checker for the modulator test path: consumes the serial bit stream produced by the team's PRBS9 generator (polynomial x^9 + x^5 + 1, as received after the channel) and self-synchronizes to it. Once locked, it free-runs a local reference sequence, flags every mismatching bit, and accumulates saturating bit and error counts for BER measurement. Loss of lock is declared when errors in a fixed observation window reach a threshold.

## Interface
- NB, 9, LFSR length / history depth
- HIGH, 9, high tap (polynomial degree)
- LOW, 5, low tap
- LOCK_THR, 32, consecutive matches required to lock
- WIN, 128, valid bits per loss-of-lock window
- UNLOCK_THR, 16, errors within one window that drop lock
- NB_CNT, 32, width of bit and error counters
- clock  in  1  single system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  global enable; low freezes all state
- i_valid  in  1  i_data is a valid received bit this cycle
- i_data  in  1  received serial bit
- i_clear  in  1  synchronous clear of o_bit_count and o_err_count
- o_lock  out  1  checker locked
- o_err  out  1  one-cycle pulse: previous valid bit mismatched
- o_bit_count  out  NB_CNT  valid bits checked while locked
- o_err_count  out  NB_CNT  mismatches while locked

## Operation
- A bit is consumed only when i_enable && i_valid ("valid bit"); otherwise every register holds.
- History register hist[NB-1:0], hist[0] = newest bit. Predicted bit p = hist[HIGH-1] ^ hist[LOW-1].
- States SEARCH and LOCKED.
- SEARCH: each valid bit shifts i_data into hist. A fill counter counts the first NB valid bits after entry; no comparisons during fill. After fill, each valid bit: if i_data == p and hist != 0, match_cnt++; otherwise match_cnt = 0. When match_cnt reaches LOCK_THR, go to LOCKED.
- The all-zero history never counts as a match (LFSR lock-up state); a constant-zero input never locks.
- Entering LOCKED: bit/error counters and window counters cleared; the fill and match counters are reset.
- LOCKED: each valid bit shifts p (not i_data) into hist, so the reference free-runs and channel errors do not propagate. o_bit_count++; if i_data != p, o_err_count++ and o_err pulses.
- Window: win_bits counts valid bits, win_errs counts errors. When win_errs reaches UNLOCK_THR, go to SEARCH (restart fill). When win_bits reaches WIN, both window counters restart from 0; a window-end bit still counts toward its own window first.
- Counters saturate at all-ones; no wrap.
- i_clear: both output counters go to 0; takes precedence over a same-cycle increment (that bit is not counted). Does not affect state, hist, or window counters.
- SEARCH → LOCKED transition and window unlock are evaluated on the same valid bit that triggers them.

## Timing
- Reset (asynchronous, any time, including mid-lock): state = SEARCH, hist = 0, all internal counters = 0, o_lock = 0, o_err = 0, o_bit_count = 0, o_err_count = 0.
- All outputs are registered. o_lock, o_err, and the counters reflect valid bit k in the cycle after k is sampled (latency 1).
- Clean stream: o_lock rises in the cycle after valid bit NB + LOCK_THR (bit 41 with defaults).
- o_err is high for exactly one cycle per erroneous bit, then 0 when the next cycle has no error. It is never asserted in SEARCH.
- Gaps in i_valid do not affect sequencing; behaviour depends only on the order of valid bits.

## Structure
- Package prbs_pkg: state encoding (SEARCH, LOCKED), default NB/HIGH/LOW, and generator seed constant 9'h1AA shared with the generator and the bench.
- One sub-module: sat_counter (width parameter; inc, clr, clr precedence, saturate), instantiated for o_bit_count and o_err_count.

## Test plan
- Generator with seed 9'h1AA drives i_valid = 1 continuously → o_lock = 1 after valid bit 41; after 1000 more bits, o_bit_count = 1000 and o_err_count = 0.
- Locked, invert a single bit → exactly one o_err pulse; o_err_count = 1; lock held; subsequent bits error-free (no propagation).
- Locked, invert 16 bits within one 128-bit window → o_lock falls the cycle after the 16th error, then relocks 41 valid bits later. Invert 15 per window → lock held.
- i_data = 0 constantly for 500 bits → o_lock stays 0. Randomized i_valid gaps on a clean stream → same counts as the gap-free run.
- i_clear asserted on the same cycle as an erroneous bit → both counters read 0 next cycle. NB_CNT = 4 with a long stream → o_bit_count holds at 15.
- i_reset pulsed mid-lock (asynchronously, between clock edges) → all outputs 0 immediately; relocks after 41 valid bits.
